// File: rtl/round_sequencer.sv
// Round index sequencer for the cipher/hash round datapaths.
// Optional count-down ordering under `ifdef ROUND_SEQ_DEC_EN.
module round_sequencer #(
    parameter int ROUNDS    = 32,
    parameter int CNT_W     = 5,
    parameter bit DONE_HOLD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             adv,
    input  logic             abort,
`ifdef ROUND_SEQ_DEC_EN
    input  logic             dec,
`endif
    output logic             busy,
    output logic [CNT_W-1:0] round,
    output logic             first,
    output logic             last,
    output logic             done
);

    if (ROUNDS == 0 || ROUNDS > 2**CNT_W) begin : g_bad_rounds
        $error("round_sequencer: ROUNDS must be in 1..2**CNT_W");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] TOP  = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic             down_q;
    logic             launch_down;
    logic [CNT_W-1:0] start_val, term_val;

`ifdef ROUND_SEQ_DEC_EN
    logic down_d;

    assign launch_down = dec;

    // Direction is captured only at launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            down_q <= 1'b0;
        end else begin
            down_q <= down_d;
        end
    end

    always_comb begin
        down_d = down_q;
        if (state_q == S_IDLE && start) begin
            down_d = dec;
        end
    end
`else
    assign launch_down = 1'b0;
    assign down_q      = 1'b0;
`endif

    assign start_val = down_q ? TOP : ZERO;
    assign term_val  = down_q ? ZERO : TOP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    round_d = launch_down ? TOP : ZERO;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    round_d = '0;
                end else if (adv) begin
                    // Terminal check comes first so the index never wraps.
                    if (round_q == term_val) begin
                        state_d = S_DONE;
                    end else if (down_q) begin
                        round_d = round_q - 1'b1;
                    end else begin
                        round_d = round_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (abort || !DONE_HOLD || !start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign round = round_q;
    assign first = busy && (round_q == start_val);
    assign last  = busy && (round_q == term_val);

endmodule
